keypad_scan: RTL

//  Input-side counterpart of the multiplexed 7-seg driver: scans a 4x4 matrix keypad by

---
 rtl/keypad_scan_pkg.sv | 45 ++++
 rtl/keypad_scan_if.sv | 35 +++
 rtl/keypad_scan_frame_cls.sv | 32 +++
 rtl/keypad_scan_prescaler.sv | 39 +++
 rtl/keypad_scan.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scan_pkg.sv
// -----------------------------------------------------------------------------
// keypad_scan_pkg
// Shared definitions for the 4x4 matrix keypad scanner.
// Contents: matrix dimensions, key-code width, FSM state encoding,
// frame class encoding, and small helper functions (popcount, column strobe).
// No ports.
// -----------------------------------------------------------------------------
package keypad_scan_pkg;

    localparam int KEY_W   = 4;
    localparam int ROWS    = 4;
    localparam int COLS    = 4;
    localparam int FRAME_W = ROWS * COLS;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DB_PRESS = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_DB_REL   = 2'd3
    } kp_state_e;

    typedef enum logic [1:0] {
        FR_EMPTY  = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_cls_e;

    // Number of set bits in a whole-matrix frame.
    function automatic logic [4:0] count_ones(input logic [FRAME_W-1:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < FRAME_W; i++) begin
            n = n + {4'd0, v[i]};
        end
        return n;
    endfunction

    // Active-low strobe pattern with only column c driven low.
    function automatic logic [3:0] col_strobe(input logic [1:0] c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c);
    endfunction

endpackage

// File: rtl/keypad_scan_if.sv
// -----------------------------------------------------------------------------
// keypad_scan_if
// Bundle between the keypad matrix / entry logic and the scanner.
//   row_in    : keypad rows, active-low (driven by the matrix side)
//   col_out   : column strobes, active-low, one low at a time
//   key_code  : last accepted key {row[1:0], col[1:0]}
//   key_valid : one-cycle pulse per accepted key (or repeat)
//   key_held  : high while the accepted key stays pressed
// Modports: master = scanner, slave = matrix / consumer side.
// -----------------------------------------------------------------------------
interface keypad_scan_if;

    logic [keypad_scan_pkg::ROWS-1:0]  row_in;
    logic [keypad_scan_pkg::COLS-1:0]  col_out;
    logic [keypad_scan_pkg::KEY_W-1:0] key_code;
    logic                              key_valid;
    logic                              key_held;

    modport master (
        input  row_in,
        output col_out,
        output key_code,
        output key_valid,
        output key_held
    );

    modport slave (
        output row_in,
        input  col_out,
        input  key_code,
        input  key_valid,
        input  key_held
    );

endinterface

// File: rtl/keypad_scan_frame_cls.sv
// -----------------------------------------------------------------------------
// keypad_frame_cls
// Classifies a 16-bit whole-matrix frame (bit index {row,col}).
//   i_frame : active-high key frame
//   o_cls   : FR_EMPTY (no key), FR_SINGLE (one key), FR_MULTI (more)
//   o_code  : index of the set bit; meaningful only for FR_SINGLE
// -----------------------------------------------------------------------------
module keypad_frame_cls
    import keypad_scan_pkg::*;
(
    input  logic [FRAME_W-1:0] i_frame,
    output frame_cls_e         o_cls,
    output logic [KEY_W-1:0]   o_code
);

    logic [4:0] w_ones;

    // Popcount selects the class; the code is the highest set bit index.
    always_comb begin
        w_ones = count_ones(i_frame);
        o_code = {KEY_W{1'b0}};
        for (int i = 0; i < FRAME_W; i++) begin
            o_code = i_frame[i] ? KEY_W'(i) : o_code;
        end
        case (w_ones)
            5'd0:    o_cls = FR_EMPTY;
            5'd1:    o_cls = FR_SINGLE;
            default: o_cls = FR_MULTI;
        endcase
    end

endmodule

// File: rtl/keypad_scan_prescaler.sv
// -----------------------------------------------------------------------------
// keypad_scan_prescaler
// Modulo-MODULO free-running counter producing a one-clock tick every MODULO
// clocks (MODULO >= 2).
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   o_tick : registered one-clock pulse, first at clock MODULO-1 after reset
// -----------------------------------------------------------------------------
module keypad_scan_prescaler #(
    parameter int MODULO = 50000,
    parameter int W      = 27
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    logic [W-1:0] r_cnt;
    logic         r_tick;

    // Count modulo MODULO; the tick flop is set one count early so the pulse
    // occupies the last clock of each period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= {W{1'b0}};
            r_tick <= 1'b0;
        end else begin
            if (r_cnt == W'(MODULO - 1)) begin
                r_cnt <= {W{1'b0}};
            end else begin
                r_cnt <= r_cnt + W'(1);
            end
            r_tick <= (r_cnt == W'(MODULO - 2));
        end
    end

    assign o_tick = r_tick;

endmodule

// File: rtl/keypad_scan.sv
// -----------------------------------------------------------------------------
// keypad_scan
// 4x4 matrix keypad scanner: strobes one active-low column per slot, samples
// synchronised active-low rows, debounces whole frames and reports keys.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   kp_if  : keypad_scan_if.master (row_in, col_out, key_code, key_valid,
//            key_held)
// Parameters: SCAN_DIV (clocks per column slot, >=4), SCAN_W (prescaler
//   width), DEBOUNCE (identical frames to accept press/release, >=1),
//   REPEAT_DLY / REPEAT_RATE (auto-repeat timing in frames).
// Optional feature macro: KEYPAD_REPEAT_EN enables auto-repeat while held;
//   without it exactly one key_valid is issued per press.
// -----------------------------------------------------------------------------
module keypad_scan
    import keypad_scan_pkg::*;
#(
    parameter int SCAN_DIV    = 50000,
    parameter int SCAN_W      = 27,
    parameter int DEBOUNCE    = 4,
    parameter int REPEAT_DLY  = 32,
    parameter int REPEAT_RATE = 8
) (
    input  logic clk,
    input  logic rst_n,
    keypad_scan_if.master kp_if
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    generate
        if ((SCAN_DIV < 4) || (DEBOUNCE < 1) || (REPEAT_DLY < 1) || (REPEAT_RATE < 1)) begin : g_bad_param
            $error("keypad_scan: illegal parameter set");
        end
    endgenerate

    logic [ROWS-1:0]    r_row_meta;
    logic [ROWS-1:0]    r_row_sync;
    logic [ROWS-1:0]    w_row_act;
    logic               w_tick;
    logic               w_frame_end;
    logic [1:0]         r_col;
    logic [COLS-1:0]    r_col_out;
    logic [FRAME_W-1:0] r_frame_acc;
    logic [FRAME_W-1:0] w_frame;
    logic [FRAME_W-1:0] r_prev_frame;
    logic [CNT_W-1:0]   r_stable;
    logic [CNT_W-1:0]   w_stable_nxt;
    frame_cls_e         w_cls;
    logic [KEY_W-1:0]   w_code;
    kp_state_e          r_state;
    kp_state_e          w_state_nxt;
    logic [KEY_W-1:0]   r_key_code;
    logic [KEY_W-1:0]   w_code_nxt;
    logic               r_key_valid;
    logic               w_valid_nxt;
    logic               r_key_held;
    logic               w_held_nxt;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_DLY + REPEAT_RATE + 1);
    logic [REP_W-1:0] r_rep_cnt;
    logic [REP_W-1:0] w_rep_cnt_nxt;
    logic [REP_W-1:0] w_rep_inc;
    logic [REP_W-1:0] w_rep_thr;
    logic             r_rep_first;
    logic             w_rep_first_nxt;
`endif

    keypad_scan_prescaler #(
        .MODULO (SCAN_DIV),
        .W      (SCAN_W)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    keypad_frame_cls u_frame_cls (
        .i_frame (w_frame),
        .o_cls   (w_cls),
        .o_code  (w_code)
    );

    // Two-flop synchroniser for the asynchronous row inputs (idle = all high).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row_meta <= 4'hF;
            r_row_sync <= 4'hF;
        end else begin
            r_row_meta <= kp_if.row_in;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_row_act   = ~r_row_sync;
    assign w_frame_end = w_tick & (r_col == 2'd3);

    // Frame as it looks after merging the current column's sample.
    always_comb begin
        w_frame = r_frame_acc;
        for (int r = 0; r < ROWS; r++) begin
            w_frame[{2'(r), r_col}] = w_row_act[r];
        end
    end

    // Stable count: MULTI clears it, a repeat of the previous frame bumps it
    // (saturating at DEBOUNCE), anything else starts a new run at 1.
    always_comb begin
        w_stable_nxt = r_stable;
        if (w_cls == FR_MULTI) begin
            w_stable_nxt = {CNT_W{1'b0}};
        end else if (w_frame == r_prev_frame) begin
            w_stable_nxt = (r_stable >= CNT_W'(DEBOUNCE)) ? r_stable : (r_stable + CNT_W'(1));
        end else begin
            w_stable_nxt = CNT_W'(1);
        end
    end

    // Column sequencing and frame accumulation on each slot tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col       <= 2'd0;
            r_col_out   <= 4'b1110;
            r_frame_acc <= {FRAME_W{1'b0}};
        end else if (w_tick) begin
            r_col       <= r_col + 2'd1;
            r_col_out   <= col_strobe(r_col + 2'd1);
            r_frame_acc <= w_frame;
        end
    end

    // Frame history used for debouncing, updated once per completed frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev_frame <= {FRAME_W{1'b0}};
            r_stable     <= {CNT_W{1'b0}};
        end else if (w_frame_end) begin
            r_prev_frame <= w_frame;
            r_stable     <= w_stable_nxt;
        end
    end

    // Next-state and output decisions; only a frame end can move the FSM and
    // a MULTI frame never does.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_key_code;
        w_held_nxt  = r_key_held;
        w_valid_nxt = 1'b0;
        if (w_frame_end && (w_cls != FR_MULTI)) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cls == FR_SINGLE) begin
                        w_state_nxt = ST_DB_PRESS;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_DB_PRESS: begin
                    if (w_cls == FR_EMPTY) begin
                        w_state_nxt = ST_IDLE;
                    end else if (w_stable_nxt >= CNT_W'(DEBOUNCE)) begin
                        w_state_nxt = ST_PRESSED;
                        w_code_nxt  = w_code;
                        w_valid_nxt = 1'b1;
                        w_held_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = ST_DB_PRESS;
                    end
                end
                ST_PRESSED: begin
                    if (w_cls == FR_EMPTY) begin
                        w_state_nxt = ST_DB_REL;
                    end else begin
                        w_state_nxt = ST_PRESSED;
                    end
                end
                ST_DB_REL: begin
                    if (w_cls != FR_EMPTY) begin
                        w_state_nxt = ST_PRESSED;
                    end else if (w_stable_nxt >= CNT_W'(DEBOUNCE)) begin
                        w_state_nxt = ST_IDLE;
                        w_held_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = ST_DB_REL;
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_held_nxt  = 1'b0;
                end
            endcase
        end else begin
            w_state_nxt = r_state;
        end

`ifdef KEYPAD_REPEAT_EN
        // Repeat timer runs only across frames that stay in PRESSED; the first
        // interval is REPEAT_DLY, later ones REPEAT_RATE.
        w_rep_cnt_nxt   = r_rep_cnt;
        w_rep_first_nxt = r_rep_first;
        w_rep_inc       = r_rep_cnt + REP_W'(1);
        w_rep_thr       = r_rep_first ? REP_W'(REPEAT_DLY) : REP_W'(REPEAT_RATE);
        if (w_frame_end) begin
            if ((r_state == ST_PRESSED) && (w_state_nxt == ST_PRESSED)) begin
                if (w_rep_inc >= w_rep_thr) begin
                    w_valid_nxt     = 1'b1;
                    w_rep_cnt_nxt   = {REP_W{1'b0}};
                    w_rep_first_nxt = 1'b0;
                end else begin
                    w_rep_cnt_nxt   = w_rep_inc;
                end
            end else begin
                w_rep_cnt_nxt   = {REP_W{1'b0}};
                w_rep_first_nxt = 1'b1;
            end
        end else begin
            w_rep_cnt_nxt = r_rep_cnt;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered key outputs; key_valid can only be set on a frame end.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_key_code  <= {KEY_W{1'b0}};
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_key_code  <= w_code_nxt;
            r_key_valid <= w_valid_nxt;
            r_key_held  <= w_held_nxt;
        end
    end

`ifdef KEYPAD_REPEAT_EN
    // Auto-repeat frame counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rep_cnt   <= {REP_W{1'b0}};
            r_rep_first <= 1'b1;
        end else begin
            r_rep_cnt   <= w_rep_cnt_nxt;
            r_rep_first <= w_rep_first_nxt;
        end
    end
`endif

    assign kp_if.col_out   = r_col_out;
    assign kp_if.key_code  = r_key_code;
    assign kp_if.key_valid = r_key_valid;
    assign kp_if.key_held  = r_key_held;

endmodule
